// File: rtl/ecg_result_display_pkg.sv
// Shared types and constants for the ECG result display.
// Pages, FSM states and double-dabble helpers.
package ecg_display_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIVE_WAIT,
    S_CONVERT,
    S_SHOW,
    S_CAPTURE
  } state_t;

  localparam logic [2:0] PAGE_LIVE  = 3'd0;
  localparam logic [2:0] PAGE_AVG   = 3'd1;
  localparam logic [2:0] PAGE_COUNT = 3'd2;
  localparam logic [2:0] PAGE_CLEAN = 3'd3;
  localparam logic [2:0] PAGE_LOW   = 3'd4;
  localparam logic [2:0] PAGE_HIGH  = 3'd5;
  localparam logic [2:0] PAGE_BLANK = 3'd7;

  localparam int BCD_W = 4;

  function automatic logic [2:0] next_page(
    input logic [2:0] p
  );
    return (p == PAGE_HIGH) ? PAGE_AVG : p + 3'd1;
  endfunction

  function automatic logic [BCD_W-1:0] dabble(
    input logic [BCD_W-1:0] n
  );
    return (n >= BCD_W'(5)) ? n + BCD_W'(3) : n;
  endfunction

endpackage

// File: rtl/ecg_result_display_if.sv
// Bundle between the heart-rate converter/control side and the display.
// master drives measurement data, slave drives the panel outputs.
interface ecg_result_display_if;
  import ecg_display_pkg::*;

  logic                  measuring;
  logic                  done;
  logic [7:0]            heart_beat_val_live;
  logic [7:0]            heart_rate_avg;
  logic [7:0]            heart_beats_count;
  logic [7:0]            heart_beats_without_violations;
  logic [7:0]            min_heart_beats_threshold_violations;
  logic [7:0]            max_heart_beats_threshold_violations;
  logic [2:0]            page_id;
  logic [BCD_W-1:0]      digit_hundreds;
  logic [BCD_W-1:0]      digit_tens;
  logic [BCD_W-1:0]      digit_ones;
  logic                  digits_valid;
  logic                  alarm;

  modport master (
    output measuring, done,
    output heart_beat_val_live, heart_rate_avg,
    output heart_beats_count,
    output heart_beats_without_violations,
    output min_heart_beats_threshold_violations,
    output max_heart_beats_threshold_violations,
    input  page_id, digit_hundreds, digit_tens,
    input  digit_ones, digits_valid, alarm
  );

  modport slave (
    input  measuring, done,
    input  heart_beat_val_live, heart_rate_avg,
    input  heart_beats_count,
    input  heart_beats_without_violations,
    input  min_heart_beats_threshold_violations,
    input  max_heart_beats_threshold_violations,
    output page_id, digit_hundreds, digit_tens,
    output digit_ones, digits_valid, alarm
  );

endinterface

// File: rtl/ecg_result_display_bin_to_bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD nibbles.
// Load on start, 8 shift cycles, then a 1-cycle ready pulse.
module bin_to_bcd8
  import ecg_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic             ready,
  output logic [BCD_W-1:0] bcd_hundreds,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_ones
);

  localparam int W = 3 * BCD_W;

  logic [7:0]   r_sh;
  logic [W-1:0] r_bcd;
  logic [2:0]   r_cnt;
  logic         r_busy;
  logic         r_ready;
  logic [W-1:0] w_adj;

  always_comb begin
    w_adj = {
      dabble(r_bcd[3*BCD_W-1:2*BCD_W]),
      dabble(r_bcd[2*BCD_W-1:BCD_W]),
      dabble(r_bcd[BCD_W-1:0])
    };
  end

  // start wins over a conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh    <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (start) begin
        r_sh   <= bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        {r_bcd, r_sh} <= {w_adj[W-2:0], r_sh, 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign ready        = r_ready;
  assign bcd_hundreds = r_bcd[3*BCD_W-1:2*BCD_W];
  assign bcd_tens     = r_bcd[2*BCD_W-1:BCD_W];
  assign bcd_ones     = r_bcd[BCD_W-1:0];

endmodule

// File: rtl/ecg_result_display.sv
// Front-panel formatter: live BPM refresh, then paged summary.
// Values are shown as 3 BCD digits via bin_to_bcd8.
module ecg_result_display
  import ecg_display_pkg::*;
#(
  parameter int PAGE_CYCLES = 50_000_000
) (
  input logic                 clk,
  input logic                 reset,
  ecg_result_display_if.slave bus
);

  localparam int CW =
    (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_MAX =
    CW'(PAGE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_done_d;
  logic [CW-1:0]    r_hold;
  logic             r_summary;
  logic [2:0]       r_target;
  logic [2:0]       r_page;
  logic [BCD_W-1:0] r_hun;
  logic [BCD_W-1:0] r_ten;
  logic [BCD_W-1:0] r_one;
  logic             r_valid;
  logic             r_alarm;
  logic [7:0]       r_avg;
  logic [7:0]       r_cnt;
  logic [7:0]       r_clean;
  logic [7:0]       r_low;
  logic [7:0]       r_high;

  logic             w_clr;
  logic             w_rise;
  logic             w_expire;
  logic             w_done_conv;
  logic [2:0]       w_page_nxt;
  logic [7:0]       w_snap_val;
  logic             w_start;
  logic             w_capture;
  logic             w_load;
  logic             w_hold_inc;
  logic             w_preload;
  logic [7:0]       w_bin;
  logic [2:0]       w_start_page;
  logic             w_busy;
  logic             w_ready;
  logic [BCD_W-1:0] w_hun;
  logic [BCD_W-1:0] w_ten;
  logic [BCD_W-1:0] w_one;

  assign w_clr       = reset | ~bus.measuring;
  assign w_rise      = bus.done & ~r_done_d;
  assign w_expire    = (r_hold == HOLD_MAX);
  assign w_done_conv = w_ready & ~w_busy;
  assign w_page_nxt  = next_page(r_page);

  always_comb begin
    case (w_page_nxt)
      PAGE_COUNT: w_snap_val = r_cnt;
      PAGE_CLEAN: w_snap_val = r_clean;
      PAGE_LOW:   w_snap_val = r_low;
      PAGE_HIGH:  w_snap_val = r_high;
      default:    w_snap_val = r_avg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // done edge preempts any hold expiry or live conversion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        w_next = S_LIVE_WAIT;
      S_LIVE_WAIT:
        if (w_rise)        w_next = S_CAPTURE;
        else if (w_expire) w_next = S_CONVERT;
      S_CONVERT:
        if (w_rise)           w_next = S_CAPTURE;
        else if (w_done_conv)
          w_next = r_summary ? S_SHOW : S_LIVE_WAIT;
      S_SHOW:
        if (w_rise)        w_next = S_CAPTURE;
        else if (w_expire) w_next = S_CONVERT;
      S_CAPTURE:
        w_next = S_CONVERT;
      default:
        w_next = S_IDLE;
    endcase
    if (!bus.measuring) w_next = S_IDLE;
  end

  always_comb begin
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_hold_inc   = 1'b0;
    w_preload    = 1'b0;
    w_bin        = '0;
    w_start_page = r_target;
    if (bus.measuring) begin
      unique case (r_state)
        S_IDLE:
          w_preload = 1'b1;
        S_LIVE_WAIT:
          if (!w_rise) begin
            w_hold_inc   = ~w_expire;
            w_start      = w_expire;
            w_bin        = bus.heart_beat_val_live;
            w_start_page = PAGE_LIVE;
          end
        S_CONVERT:
          w_load = ~w_rise & w_done_conv;
        S_SHOW:
          if (!w_rise) begin
            w_hold_inc   = ~w_expire;
            w_start      = w_expire;
            w_bin        = w_snap_val;
            w_start_page = w_page_nxt;
          end
        S_CAPTURE: begin
          w_capture    = 1'b1;
          w_start      = 1'b1;
          w_bin        = bus.heart_rate_avg;
          w_start_page = PAGE_AVG;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_done_d <= 1'b0;
    else       r_done_d <= bus.done;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_hold    <= '0;
      r_summary <= 1'b0;
      r_target  <= PAGE_LIVE;
      r_page    <= PAGE_BLANK;
      r_hun     <= '0;
      r_ten     <= '0;
      r_one     <= '0;
      r_valid   <= 1'b0;
      r_alarm   <= 1'b0;
      r_avg     <= '0;
      r_cnt     <= '0;
      r_clean   <= '0;
      r_low     <= '0;
      r_high    <= '0;
    end else begin
      if (w_preload)       r_hold <= HOLD_MAX;
      else if (w_load)     r_hold <= '0;
      else if (w_hold_inc) r_hold <= r_hold + CW'(1);
      if (w_start) r_target <= w_start_page;
      if (w_capture) begin
        r_avg     <= bus.heart_rate_avg;
        r_cnt     <= bus.heart_beats_count;
        r_clean   <= bus.heart_beats_without_violations;
        r_low     <= bus.min_heart_beats_threshold_violations;
        r_high    <= bus.max_heart_beats_threshold_violations;
        r_alarm   <= |bus.min_heart_beats_threshold_violations
                   | |bus.max_heart_beats_threshold_violations;
        r_summary <= 1'b1;
      end
      if (w_load) begin
        r_hun   <= w_hun;
        r_ten   <= w_ten;
        r_one   <= w_one;
        r_page  <= r_target;
        r_valid <= 1'b1;
      end
    end
  end

  bin_to_bcd8 u_bcd (
    .clk          (clk),
    .reset        (w_clr),
    .start        (w_start),
    .bin          (w_bin),
    .busy         (w_busy),
    .ready        (w_ready),
    .bcd_hundreds (w_hun),
    .bcd_tens     (w_ten),
    .bcd_ones     (w_one)
  );

  assign bus.page_id        = r_page;
  assign bus.digit_hundreds = r_hun;
  assign bus.digit_tens     = r_ten;
  assign bus.digit_ones     = r_one;
  assign bus.digits_valid   = r_valid;
  assign bus.alarm          = r_alarm;

endmodule
